// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, error codes, frame constants
// and the parity helper. Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE      = 3'd0;
  localparam ps2_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_state_t ST_RTS       = 3'd2;
  localparam ps2_state_t ST_WAIT_EDGE = 3'd3;
  localparam ps2_state_t ST_XFER      = 3'd4;
  localparam ps2_state_t ST_RELEASE   = 3'd5;
  localparam ps2_state_t ST_FAIL      = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_XFER_TO  = 2'b10;
  localparam logic [1:0] ERR_NO_ACK   = 2'b11;

  localparam int unsigned PS2_DATA_BITS   = 8;
  localparam int unsigned PS2_PARITY_EDGE = 9;
  localparam int unsigned PS2_STOP_EDGE   = 10;
  localparam int unsigned PS2_ACK_EDGE    = 11;
  localparam int unsigned EDGE_CNT_W      = 4;

  // Odd parity bit: set so the byte plus parity has an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the raw PS/2 clock and data lines plus a
// one-cycle strobe on each falling edge of the synchronised clock.
// Ports: clk, reset (sync, active-high), clk_raw/dat_raw (async line levels),
//        clk_sync/dat_sync (synchronised levels), clk_fall_c (falling-edge strobe).
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall_c
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Reset to the idle (released, pulled-up) level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_raw};
      dat_ff   <= {dat_ff[0], dat_raw};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync   = clk_ff[1];
  assign dat_sync   = dat_ff[1];
  assign clk_fall_c = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts out one command byte with odd parity on device clock edges and
// checks the device acknowledge. Lines are driven through active-low enables.
// Ports: CLOCK_50, reset (sync, active-high), send_cmd/cmd_byte (request),
//        ps2_clk_in/ps2_dat_in (raw lines), ps2_clk_oe/ps2_dat_oe (1 = pull low),
//        busy, done/error (one-cycle pulses), err_code (sticky until next send).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 6000,
  parameter int unsigned RTS_CYCLES           = 250,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_cmd,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned WDOG_MAX = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                                     START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
  localparam int unsigned WDOG_W   = $clog2(WDOG_MAX + 1);
  localparam int unsigned PH_MAX   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

  logic clk_sync, dat_sync, clk_fall_c;

  ps2_state_t                   state, state_d;
  logic [PH_W-1:0]              phase_cnt, phase_d;
  logic [WDOG_W-1:0]            wdog, wdog_d, wdog_inc;
  logic [EDGE_CNT_W-1:0]        edge_cnt, edge_d, edge_nxt;
  logic [PS2_DATA_BITS-1:0]     data_q, data_d;
  logic                         parity_q, parity_d;
  logic                         clk_oe_d, dat_oe_d, busy_d, done_d, error_d;
  logic [1:0]                   err_d;

  ps2_sync_edge u_sync (
    .clk        (CLOCK_50),
    .reset      (reset),
    .clk_raw    (ps2_clk_in),
    .dat_raw    (ps2_dat_in),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall_c (clk_fall_c)
  );

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d  = state;
    phase_d  = phase_cnt;
    wdog_d   = wdog;
    edge_d   = edge_cnt;
    data_d   = data_q;
    parity_d = parity_q;
    clk_oe_d = ps2_clk_oe;
    dat_oe_d = ps2_dat_oe;
    err_d    = err_code;
    done_d   = 1'b0;
    error_d  = 1'b0;
    wdog_inc = (wdog == WDOG_W'(WDOG_MAX)) ? wdog : wdog + WDOG_W'(1);
    edge_nxt = edge_cnt + EDGE_CNT_W'(1);

    case (state)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (send_cmd) begin
          data_d   = cmd_byte;
          parity_d = odd_parity(cmd_byte);
          err_d    = ERR_NONE;
          phase_d  = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (phase_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
          phase_d  = '0;
          dat_oe_d = 1'b1;
          state_d  = ST_RTS;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      ST_RTS: begin
        if (phase_cnt == PH_W'(RTS_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          wdog_d   = '0;
          edge_d   = '0;
          state_d  = ST_WAIT_EDGE;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      ST_WAIT_EDGE: begin
        // The first device edge is edge 1 and already carries data bit 0.
        if (clk_fall_c) begin
          wdog_d   = '0;
          edge_d   = EDGE_CNT_W'(1);
          dat_oe_d = ~data_q[0];
          state_d  = ST_XFER;
        end else if (wdog_inc >= WDOG_W'(START_TIMEOUT_CYCLES)) begin
          err_d   = ERR_START_TO;
          state_d = ST_FAIL;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_XFER: begin
        wdog_d = wdog_inc;
        if (wdog_inc >= WDOG_W'(XFER_TIMEOUT_CYCLES)) begin
          err_d   = ERR_XFER_TO;
          state_d = ST_FAIL;
        end else if (clk_fall_c) begin
          edge_d = edge_nxt;
          if (edge_nxt <= EDGE_CNT_W'(PS2_DATA_BITS)) begin
            dat_oe_d = ~data_q[edge_cnt[2:0]];
          end else if (edge_nxt == EDGE_CNT_W'(PS2_PARITY_EDGE)) begin
            dat_oe_d = ~parity_q;
          end else if (edge_nxt == EDGE_CNT_W'(PS2_STOP_EDGE)) begin
            dat_oe_d = 1'b0;
          end else if (edge_nxt == EDGE_CNT_W'(PS2_ACK_EDGE)) begin
            if (!dat_sync) begin
              state_d = ST_RELEASE;
            end else begin
              err_d   = ERR_NO_ACK;
              state_d = ST_FAIL;
            end
          end
        end
      end
      ST_RELEASE: begin
        wdog_d = wdog_inc;
        if (wdog_inc >= WDOG_W'(XFER_TIMEOUT_CYCLES)) begin
          err_d   = ERR_XFER_TO;
          state_d = ST_FAIL;
        end else if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Entering FAIL: release both lines and pulse error for that one cycle.
    if (state_d == ST_FAIL) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      error_d  = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      wdog       <= '0;
      edge_cnt   <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_d;
      phase_cnt  <= phase_d;
      wdog       <= wdog_d;
      edge_cnt   <= edge_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      err_code   <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain bus and a device
// model that clocks at a 40-cycle period (20 low, 20 high).
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_cmd;
  logic [7:0] cmd_byte;
  logic       dev_clk_low;
  logic       dev_dat_low;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, error;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Wired-AND of host and device pull-downs.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES       (20),
    .RTS_CYCLES           (5),
    .START_TIMEOUT_CYCLES (200),
    .XFER_TIMEOUT_CYCLES  (2000)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .send_cmd   (send_cmd),
    .cmd_byte   (cmd_byte),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Send a byte and check inhibit (20 cycles) and RTS (5 cycles) timing.
  // Returns at the first negedge where the clock line has been released.
  task automatic issue_and_release(input logic [7:0] b);
    int bad;
    bad = 0;
    @(negedge clk); send_cmd = 1'b1; cmd_byte = b;
    @(negedge clk); send_cmd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!(ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && busy === 1'b1)) bad++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (!(ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1)) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL handshake_%h: %0d bad cycles, required 0", b, bad);
    end
    n_cmp++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b011) begin
      n_bad++;
      $display("FAIL release_%h: clk_oe,dat_oe,busy=%b required 011", b, {ps2_clk_oe, ps2_dat_oe, busy});
    end
  endtask

  // Device clocks n_edges edges; seen[e-1] records dat_oe late in low phase e.
  // With ack it pulls data low after edge 10 and releases it with edge 11's rise.
  // Returns on the negedge where the last edge's clock was released.
  task automatic dev_frame(input int n_edges, input bit ack, output logic [10:0] seen);
    seen = '0;
    repeat (10) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      repeat (19) @(negedge clk);
      seen[4'(e - 1)] = ps2_dat_oe;
      @(negedge clk);
      dev_clk_low = 1'b0;
      if (e == 11) dev_dat_low = 1'b0;
      if (e < n_edges) begin
        if (e == 10 && ack) dev_dat_low = 1'b1;
        repeat (20) @(negedge clk);
      end
    end
  endtask

  // Acked frame; done must show on the 3rd negedge after the bus goes idle.
  task automatic acked_frame(input logic [7:0] b, input logic [9:0] exp_oe);
    logic [10:0] seen;
    logic [1:0]  early;
    issue_and_release(b);
    dev_frame(11, 1'b1, seen);
    n_cmp++;
    if (seen[9:0] !== exp_oe) begin
      n_bad++;
      $display("FAIL bits_%h: dat_oe edges10..1=%b required %b", b, seen[9:0], exp_oe);
    end
    @(negedge clk); early[0] = done;
    @(negedge clk); early[1] = done;
    n_cmp++;
    if (early !== 2'b00) begin
      n_bad++;
      $display("FAIL early_done_%h: done=%b required 00", b, early);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, error, err_code} !== 5'b10000) begin
      n_bad++;
      $display("FAIL done_%h: done,busy,error,err=%b required 10000", b, {done, busy, error, err_code});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_width_%h: done=%b required 0", b, done);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ps2_clk_oe, ps2_dat_oe, busy, done, error, err_code} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset: outputs=%b required 0000000",
               {ps2_clk_oe, ps2_dat_oe, busy, done, error, err_code});
    end
  endtask

  task automatic test_send_ed();
    // 0xED: ~bits LSB first 0,1,0,0,1,0,0,0; parity 1 -> 0; stop 0.
    acked_frame(8'hED, 10'b00_0001_0010);
  endtask

  task automatic test_send_00();
    // 0x00: all data edges 1, parity 1 -> 0, stop 0.
    acked_frame(8'h00, 10'b00_1111_1111);
  endtask

  task automatic test_start_timeout();
    int cnt;
    issue_and_release(8'h80);
    cnt = 0;
    while (error !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 200) begin
      n_bad++;
      $display("FAIL start_to_latency: %0d cycles required 200", cnt);
    end
    n_cmp++;
    if ({err_code, ps2_clk_oe, ps2_dat_oe} !== 4'b0100) begin
      n_bad++;
      $display("FAIL start_to_code: err,clk_oe,dat_oe=%b required 0100", {err_code, ps2_clk_oe, ps2_dat_oe});
    end
    @(negedge clk);
    n_cmp++;
    if ({error, busy, err_code} !== 4'b0001) begin
      n_bad++;
      $display("FAIL start_to_after: error,busy,err=%b required 0001", {error, busy, err_code});
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_xfer_timeout();
    logic [10:0] seen;
    int cnt;
    bit found;
    issue_and_release(8'h55);
    cnt = 0;
    found = 0;
    fork
      dev_frame(5, 1'b0, seen);
      begin
        for (int i = 0; i < 200 && !found; i++) begin
          if (ps2_dat_oe === 1'b0) found = 1;
          else @(negedge clk);
        end
        while (found && error !== 1'b1 && cnt < 3000) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    n_cmp++;
    if (cnt !== 2000) begin
      n_bad++;
      $display("FAIL xfer_to_latency: %0d cycles after edge 1 required 2000 (edge1 seen=%0d)", cnt, found);
    end
    n_cmp++;
    if ({err_code, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
      n_bad++;
      $display("FAIL xfer_to_code: err,clk_oe,dat_oe=%b required 1000", {err_code, ps2_clk_oe, ps2_dat_oe});
    end
    n_cmp++;
    if (seen[4:0] !== 5'b01010) begin
      n_bad++;
      $display("FAIL bits_55: dat_oe edges5..1=%b required 01010", seen[4:0]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_no_ack();
    logic [10:0] seen;
    logic [1:0]  code;
    int n_err, n_done;
    n_err = 0; n_done = 0; code = 2'b00;
    issue_and_release(8'hF4);
    fork
      dev_frame(11, 1'b0, seen);
      begin
        for (int i = 0; i < 480; i++) begin
          @(negedge clk);
          if (error === 1'b1) begin n_err++; code = err_code; end
          if (done === 1'b1) n_done++;
        end
      end
    join
    n_cmp++;
    if (n_err !== 1 || n_done !== 0) begin
      n_bad++;
      $display("FAIL no_ack_pulses: error=%0d done=%0d required 1 and 0", n_err, n_done);
    end
    n_cmp++;
    if (code !== 2'b11) begin
      n_bad++;
      $display("FAIL no_ack_code: err_code=%b required 11", code);
    end
    n_cmp++;
    // 0xF4: ~bits 1,1,0,1,0,0,0,0; parity 0 -> 1; stop 0.
    if (seen[9:0] !== 10'b01_0000_1011) begin
      n_bad++;
      $display("FAIL bits_f4: dat_oe edges10..1=%b required 0100001011", seen[9:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seen;
    int cnt;
    @(negedge clk); send_cmd = 1'b1; cmd_byte = 8'hED;
    @(negedge clk); cmd_byte = 8'h00;
    @(negedge clk); send_cmd = 1'b0;
    cnt = 0;
    while (ps2_clk_oe !== 1'b0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 24) begin
      n_bad++;
      $display("FAIL b2b_release: %0d cycles required 24", cnt);
    end
    dev_frame(11, 1'b1, seen);
    n_cmp++;
    if (seen[9:0] !== 10'b00_0001_0010) begin
      n_bad++;
      $display("FAIL b2b_bits: dat_oe edges10..1=%b required 0000010010", seen[9:0]);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_done: done,busy=%b required 10", {done, busy});
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [10:0] seen;
    issue_and_release(8'h00);
    dev_frame(5, 1'b0, seen);
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({ps2_dat_oe, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset: dat_oe,busy=%b required 11", {ps2_dat_oe, busy});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({ps2_clk_oe, ps2_dat_oe, busy, err_code} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_reset: clk_oe,dat_oe,busy,err=%b required 00000",
               {ps2_clk_oe, ps2_dat_oe, busy, err_code});
    end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    send_cmd = 1'b0;
    cmd_byte = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    test_reset();
    test_send_ed();
    test_send_00();
    test_start_timeout();
    test_xfer_timeout();
    test_no_ack();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
